// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: receiver FSM states, parity constants, parity helper
// Purpose: shared by the TX parity generator and the RX frame checker, so that both sides
//          compute the parity bit in exactly the same way.
// Ports:   none (package)
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest data word the helper accepts. Callers zero-extend narrower words,
    // and zero padding leaves the XOR reduction unchanged.
    localparam int PAR_MAX_W = 32;

    // Parity bit the transmitter sends for this word.
    function automatic logic exp_parity(input logic [PAR_MAX_W-1:0] data, input logic typ);
        return (typ == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// rtl/uart_rx_frame_check_if.sv - bit-sampler to frame-checker interface
// Purpose: groups the sampler strobes, line configuration and checker results.
// Signals: start_det, bit_valid, sampled_bit, PAR_EN, PAR_TYP   (sampler/config -> checker)
//          P_DATA, data_valid, par_err, stp_err, busy          (checker -> consumer)
// Modports: master = sampler/config side, slave = frame checker
interface uart_rx_frame_check_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start_det;
    logic                  bit_valid;
    logic                  sampled_bit;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output start_det, bit_valid, sampled_bit, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  start_det, bit_valid, sampled_bit, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_frame_check.sv
// rtl/uart_rx_frame_check.sv - UART receive frame deserializer with parity/stop checking
// Purpose: shifts in DATA_WIDTH data bits LSB first, then the optional parity bit and the
//          stop bit; raises one-cycle data_valid / par_err / stp_err pulses the cycle after
//          the stop-bit strobe. P_DATA only updates on a good frame.
// Ports:   clk  - single clock
//          rst  - synchronous, active-high reset
//          bus  - uart_rx_frame_check_if.slave (sampler strobes, config, results)
import uart_pkg::*;

module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    uart_rx_frame_check_if.slave bus
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_cfg_en;
    logic                  r_cfg_typ;
    logic                  r_rx_par;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    logic w_par_err;
    logic w_stp_err;

    // Frame verdict, valid while the stop bit is being strobed in.
    assign w_par_err = r_cfg_en & (r_rx_par != exp_parity(PAR_MAX_W'(r_shift), r_cfg_typ));
    assign w_stp_err = ~bus.sampled_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_p_data     <= '0;
            r_cfg_en     <= 1'b0;
            r_cfg_typ    <= 1'b0;
            r_rx_par     <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            // Result flags are single-cycle pulses.
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // A bit_valid coinciding with start_det belongs to no frame yet.
                    if (bus.start_det) begin
                        r_state   <= ST_DATA;
                        r_cfg_en  <= bus.PAR_EN;
                        r_cfg_typ <= bus.PAR_TYP;
                        r_cnt     <= '0;
                        r_shift   <= '0;
                    end
                end
                ST_DATA: begin
                    if (bus.bit_valid) begin
                        // LSB arrives first, so after DATA_WIDTH right shifts it sits at bit 0.
                        r_shift <= {bus.sampled_bit, r_shift[DATA_WIDTH-1:1]};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= r_cfg_en ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bus.bit_valid) begin
                        r_rx_par <= bus.sampled_bit;
                        r_state  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // start_det here is dropped; the next frame may start one cycle later.
                    if (bus.bit_valid) begin
                        r_par_err    <= w_par_err;
                        r_stp_err    <= w_stp_err;
                        r_data_valid <= ~w_par_err & ~w_stp_err;
                        if (~w_par_err & ~w_stp_err) begin
                            r_p_data <= r_shift;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.P_DATA     = r_p_data;
    assign bus.data_valid = r_data_valid;
    assign bus.par_err    = r_par_err;
    assign bus.stp_err    = r_stp_err;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule
